// File: rtl/ball_motion_ctrl.sv
// Pong ball physics: serve timing, per-frame motion with border/paddle bounces and scoring.
// Advances once per frame on a tick taken from the VGA scan position.
module ball_motion_ctrl #(
   parameter int BALL_SIZE    = 5,
   parameter int SPEED_X      = 2,
   parameter int SPEED_Y      = 1,
   parameter int TOP_LIMIT    = 2,
   parameter int BOTTOM_LIMIT = 478,
   parameter int LEFT_LIMIT   = 2,
   parameter int RIGHT_LIMIT  = 636,
   parameter int P1_X         = 20,
   parameter int P2_X         = 610,
   parameter int PADDLE_W     = 10,
   parameter int PADDLE_H     = 120,
   parameter int CENTER_X     = 318,
   parameter int CENTER_Y     = 238,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9,
   parameter int TICK_LINE    = 480
) (
   input  logic       pixel_clk,
   input  logic       reset_n,
   input  logic [9:0] X_pix,
   input  logic [9:0] Y_pix,
   input  logic [9:0] p1_paddle_y,
   input  logic [9:0] p2_paddle_y,
   input  logic       serve_req,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic       point_p1,
   output logic       point_p2,
   output logic       paddle_hit,
   output logic       game_over
);

   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

   localparam logic [10:0] BALL_W    = 11'(BALL_SIZE);
   localparam logic [10:0] SPX       = 11'(SPEED_X);
   localparam logic [10:0] SPY       = 11'(SPEED_Y);
   localparam logic [10:0] TOP_W     = 11'(TOP_LIMIT);
   localparam logic [10:0] BOTTOM_W  = 11'(BOTTOM_LIMIT);
   localparam logic [10:0] LEFT_W    = 11'(LEFT_LIMIT);
   localparam logic [10:0] RIGHT_W   = 11'(RIGHT_LIMIT);
   localparam logic [10:0] P1_FACE   = 11'(P1_X + PADDLE_W);
   localparam logic [10:0] P2_FACE   = 11'(P2_X);
   localparam logic [10:0] PAD_H     = 11'(PADDLE_H);
   localparam logic [9:0]  CX        = 10'(CENTER_X);
   localparam logic [9:0]  CY        = 10'(CENTER_Y);
   localparam logic [9:0]  TICK_Y    = 10'(TICK_LINE);
   localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

   typedef enum logic [2:0] {IDLE, SERVE_WAIT, MOVE, SCORED, GAME_OVER} state_t;

   state_t           state, state_next;
   logic             tick_cond, tick_cond_q, tick;
   logic [CNT_W-1:0] serve_cnt, serve_cnt_next;
   logic             dir_right, dir_down, p1_scored;
   logic             dir_right_next, dir_down_next, p1_scored_next;
   logic [9:0]       ball_x_next, ball_y_next;
   logic [3:0]       score_p1_next, score_p2_next;
   logic             point_p1_next, point_p2_next, paddle_hit_next, game_over_next;
   logic [10:0]      x_w, y_w, p1_w, p2_w;
   logic [9:0]       x_step, y_step;
   logic             down_step, right_step, overlap1, overlap2;
   logic             bounce_hit, goal_p1, goal_p2, win_now;

   assign x_w       = {1'b0, ball_x};
   assign y_w       = {1'b0, ball_y};
   assign p1_w      = {1'b0, p1_paddle_y};
   assign p2_w      = {1'b0, p2_paddle_y};
   assign tick_cond = (X_pix == 10'd0) && (Y_pix == TICK_Y);
   assign win_now   = p1_scored ? (score_p1 == WIN - 4'd1) : (score_p2 == WIN - 4'd1);

   // Frame tick: one cycle on the rising edge of the scan-position match
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cond_q <= 1'b0;
         tick        <= 1'b0;
      end else begin
         tick_cond_q <= tick_cond;
         tick        <= tick_cond & ~tick_cond_q;
      end
   end

   // Candidate motion for this frame, always computed from the pre-tick position
   always_comb begin
      y_step    = ball_y;
      down_step = dir_down;
      if (dir_down) begin
         if (y_w + BALL_W + SPY > BOTTOM_W) begin
            y_step    = 10'(BOTTOM_W - BALL_W);
            down_step = 1'b0;
         end else begin
            y_step = 10'(y_w + SPY);
         end
      end else begin
         if (y_w < TOP_W + SPY) begin
            y_step    = 10'(TOP_W);
            down_step = 1'b1;
         end else begin
            y_step = 10'(y_w - SPY);
         end
      end

      overlap1 = (y_w + BALL_W > p1_w) && (y_w < p1_w + PAD_H);
      overlap2 = (y_w + BALL_W > p2_w) && (y_w < p2_w + PAD_H);

      x_step     = ball_x;
      right_step = dir_right;
      bounce_hit = 1'b0;
      goal_p1    = 1'b0;
      goal_p2    = 1'b0;
      // Paddle checks come first so a save always beats a goal
      if (!dir_right) begin
         if (x_w >= P1_FACE && x_w < P1_FACE + SPX && overlap1) begin
            x_step     = 10'(P1_FACE);
            right_step = 1'b1;
            bounce_hit = 1'b1;
         end else if (x_w < LEFT_W + SPX) begin
            goal_p2 = 1'b1;
         end else begin
            x_step = 10'(x_w - SPX);
         end
      end else begin
         if (x_w + BALL_W <= P2_FACE && x_w + BALL_W + SPX > P2_FACE && overlap2) begin
            x_step     = 10'(P2_FACE - BALL_W);
            right_step = 1'b0;
            bounce_hit = 1'b1;
         end else if (x_w + BALL_W + SPX > RIGHT_W) begin
            goal_p1 = 1'b1;
         end else begin
            x_step = 10'(x_w + SPX);
         end
      end
   end

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (serve_req) state_next = SERVE_WAIT;
         SERVE_WAIT: if (tick && serve_cnt == SERVE_LAST) state_next = MOVE;
         MOVE:       if (tick && (goal_p1 || goal_p2)) state_next = SCORED;
         SCORED:     state_next = win_now ? GAME_OVER : SERVE_WAIT;
         GAME_OVER:  if (serve_req) state_next = SERVE_WAIT;
         default:    state_next = IDLE;
      endcase
   end

   // Next values for every registered output and the ball's hidden state
   always_comb begin
      ball_x_next     = ball_x;
      ball_y_next     = ball_y;
      dir_right_next  = dir_right;
      dir_down_next   = dir_down;
      p1_scored_next  = p1_scored;
      score_p1_next   = score_p1;
      score_p2_next   = score_p2;
      serve_cnt_next  = '0;
      point_p1_next   = 1'b0;
      point_p2_next   = 1'b0;
      paddle_hit_next = 1'b0;
      game_over_next  = (state_next == GAME_OVER);
      case (state)
         IDLE: begin
            ball_x_next = CX;
            ball_y_next = CY;
         end
         SERVE_WAIT: begin
            serve_cnt_next = tick ? serve_cnt + 1'b1 : serve_cnt;
         end
         MOVE: begin
            if (tick) begin
               if (goal_p1 || goal_p2) begin
                  p1_scored_next = goal_p1;
               end else begin
                  ball_x_next     = x_step;
                  ball_y_next     = y_step;
                  dir_right_next  = right_step;
                  dir_down_next   = down_step;
                  paddle_hit_next = bounce_hit;
               end
            end
         end
         SCORED: begin
            ball_x_next    = CX;
            ball_y_next    = CY;
            dir_right_next = p1_scored;
            dir_down_next  = ~dir_down;
            if (p1_scored) begin
               score_p1_next = score_p1 + 4'd1;
               point_p1_next = 1'b1;
            end else begin
               score_p2_next = score_p2 + 4'd1;
               point_p2_next = 1'b1;
            end
         end
         GAME_OVER: begin
            ball_x_next = CX;
            ball_y_next = CY;
            if (serve_req) begin
               score_p1_next = 4'd0;
               score_p2_next = 4'd0;
            end
         end
         default: begin
            ball_x_next = CX;
            ball_y_next = CY;
         end
      endcase
   end

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         ball_x     <= CX;
         ball_y     <= CY;
         dir_right  <= 1'b1;
         dir_down   <= 1'b1;
         p1_scored  <= 1'b0;
         score_p1   <= 4'd0;
         score_p2   <= 4'd0;
         serve_cnt  <= '0;
         point_p1   <= 1'b0;
         point_p2   <= 1'b0;
         paddle_hit <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         ball_x     <= ball_x_next;
         ball_y     <= ball_y_next;
         dir_right  <= dir_right_next;
         dir_down   <= dir_down_next;
         p1_scored  <= p1_scored_next;
         score_p1   <= score_p1_next;
         score_p2   <= score_p2_next;
         serve_cnt  <= serve_cnt_next;
         point_p1   <= point_p1_next;
         point_p2   <= point_p2_next;
         paddle_hit <= paddle_hit_next;
         game_over  <= game_over_next;
      end
   end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: directed frame sequences with hand-computed ball
// positions, scores and cumulative pulse counts, compared by an independent monitor.
module tb_ball_motion_ctrl;

   logic       pixel_clk = 1'b0;
   logic       reset_n;
   logic [9:0] X_pix, Y_pix, p1_paddle_y, p2_paddle_y;
   logic       serve_req;
   logic [9:0] ball_x, ball_y;
   logic [3:0] score_p1, score_p2;
   logic       point_p1, point_p2, paddle_hit, game_over;

   typedef struct {
      string name;
      int    x, y, s1, s2, go, hits, pp1, pp2;
   } expect_t;

   expect_t sbQueue[$];
   event    sampleStrobe;
   int      checkCount   = 0;
   int      errorCount   = 0;
   int      hitCount     = 0;
   int      pointP1Count = 0;
   int      pointP2Count = 0;

   ball_motion_ctrl dut (
      .pixel_clk  (pixel_clk),
      .reset_n    (reset_n),
      .X_pix      (X_pix),
      .Y_pix      (Y_pix),
      .p1_paddle_y(p1_paddle_y),
      .p2_paddle_y(p2_paddle_y),
      .serve_req  (serve_req),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .score_p1   (score_p1),
      .score_p2   (score_p2),
      .point_p1   (point_p1),
      .point_p2   (point_p2),
      .paddle_hit (paddle_hit),
      .game_over  (game_over)
   );

   always #5 pixel_clk = ~pixel_clk;

   // Pulse counters: every high cycle counts, so a stretched pulse shows up as an extra count
   always @(negedge pixel_clk) begin
      if (paddle_hit) hitCount++;
      if (point_p1)   pointP1Count++;
      if (point_p2)   pointP2Count++;
   end

   task automatic compareField(input string name, input string field, input int actual, input int required);
      checkCount++;
      if (actual != required) begin
         errorCount++;
         $display("[TB] FAIL %s %s: actual %0d required %0d", name, field, actual, required);
      end
   endtask

   // Monitor: drains the scoreboard whenever the DUT presents a settled frame
   initial begin
      expect_t e;
      forever begin
         @(sampleStrobe);
         while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            compareField(e.name, "ball_x",     int'(ball_x),    e.x);
            compareField(e.name, "ball_y",     int'(ball_y),    e.y);
            compareField(e.name, "score_p1",   int'(score_p1),  e.s1);
            compareField(e.name, "score_p2",   int'(score_p2),  e.s2);
            compareField(e.name, "game_over",  int'(game_over), e.go);
            compareField(e.name, "paddle_hits", hitCount,       e.hits);
            compareField(e.name, "point_p1s",  pointP1Count,    e.pp1);
            compareField(e.name, "point_p2s",  pointP2Count,    e.pp2);
         end
      end
   end

   // One frame = tick condition held for holdCycles, then a few idle scan positions
   task automatic applyStimulus(input int nFrames, input int holdCycles);
      repeat (nFrames) begin
         @(negedge pixel_clk);
         X_pix = 10'd0;
         Y_pix = 10'd480;
         repeat (holdCycles - 1) @(negedge pixel_clk);
         @(negedge pixel_clk);
         X_pix = 10'd100;
         Y_pix = 10'd100;
         repeat (3) @(negedge pixel_clk);
      end
   endtask

   task automatic checkOutput(input string name, input int x, input int y, input int s1, input int s2,
                              input int go, input int hits, input int pp1, input int pp2);
      expect_t e;
      e.name = name; e.x = x; e.y = y; e.s1 = s1; e.s2 = s2;
      e.go = go; e.hits = hits; e.pp1 = pp1; e.pp2 = pp2;
      sbQueue.push_back(e);
      -> sampleStrobe;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      errorCount++;
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n     = 1'b0;
      serve_req   = 1'b0;
      X_pix       = 10'd100;
      Y_pix       = 10'd100;
      p1_paddle_y = 10'd0;
      p2_paddle_y = 10'd360;
      repeat (3) @(negedge pixel_clk);
      checkOutput("reset", 318, 238, 0, 0, 0, 0, 0, 0);
      @(negedge pixel_clk);
      reset_n = 1'b1;

      applyStimulus(10, 1);
      checkOutput("idle10", 318, 238, 0, 0, 0, 0, 0, 0);

      // Serve held high into MOVE to show it is ignored there
      @(negedge pixel_clk);
      serve_req = 1'b1;
      applyStimulus(60, 1);
      checkOutput("serveHold", 318, 238, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1);
      checkOutput("firstMove", 320, 239, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 3);
      checkOutput("heldTick", 322, 240, 0, 0, 0, 0, 0, 0);
      serve_req = 1'b0;

      applyStimulus(141, 1);
      checkOutput("m143", 604, 381, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1);
      checkOutput("p2Bounce", 605, 382, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 1);
      checkOutput("m145", 603, 383, 0, 0, 0, 1, 0, 0);
      applyStimulus(90, 1);
      checkOutput("m235", 423, 473, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 1);
      checkOutput("bottomClamp", 421, 473, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 1);
      checkOutput("m237", 419, 472, 0, 0, 0, 1, 0, 0);

      p1_paddle_y = 10'd250;
      applyStimulus(195, 1);
      checkOutput("p1Bounce", 30, 277, 0, 0, 0, 2, 0, 0);
      applyStimulus(1, 1);
      checkOutput("m433", 32, 276, 0, 0, 0, 2, 0, 0);
      applyStimulus(274, 1);
      checkOutput("m707", 580, 2, 0, 0, 0, 2, 0, 0);
      applyStimulus(1, 1);
      checkOutput("topClamp", 582, 2, 0, 0, 0, 2, 0, 0);
      applyStimulus(1, 1);
      checkOutput("m709", 584, 3, 0, 0, 0, 2, 0, 0);

      p2_paddle_y = 10'd500;
      applyStimulus(23, 1);
      checkOutput("m732", 630, 26, 0, 0, 0, 2, 0, 0);
      applyStimulus(1, 1);
      checkOutput("p1Goal", 318, 238, 1, 0, 0, 2, 1, 0);

      applyStimulus(60, 1);
      checkOutput("serve2Hold", 318, 238, 1, 0, 0, 2, 1, 0);
      applyStimulus(1, 1);
      checkOutput("serve2Move", 320, 237, 1, 0, 0, 2, 1, 0);
      applyStimulus(156, 1);
      checkOutput("point2", 318, 238, 2, 0, 0, 2, 2, 0);
      for (int p = 3; p <= 9; p++) begin
         applyStimulus(217, 1);
         checkOutput($sformatf("point%0d", p), 318, 238, p, 0, (p == 9) ? 1 : 0, 2, p, 0);
      end

      applyStimulus(5, 1);
      checkOutput("overFrozen", 318, 238, 9, 0, 1, 2, 9, 0);
      @(negedge pixel_clk);
      serve_req = 1'b1;
      @(negedge pixel_clk);
      serve_req = 1'b0;
      @(negedge pixel_clk);
      checkOutput("restart", 318, 238, 0, 0, 0, 2, 9, 0);

      p2_paddle_y = 10'd50;
      p1_paddle_y = 10'd500;
      applyStimulus(60, 1);
      checkOutput("serve3Hold", 318, 238, 0, 0, 0, 2, 9, 0);
      applyStimulus(1, 1);
      checkOutput("k1", 320, 237, 0, 0, 0, 2, 9, 0);
      applyStimulus(142, 1);
      checkOutput("k143", 604, 95, 0, 0, 0, 2, 9, 0);
      applyStimulus(1, 1);
      checkOutput("k144", 605, 94, 0, 0, 0, 3, 9, 0);
      applyStimulus(301, 1);
      checkOutput("k445", 3, 210, 0, 0, 0, 3, 9, 0);
      applyStimulus(1, 1);
      checkOutput("p2Goal", 318, 238, 0, 1, 0, 3, 9, 1);
      applyStimulus(60, 1);
      checkOutput("serve4Hold", 318, 238, 0, 1, 0, 3, 9, 1);
      applyStimulus(1, 1);
      checkOutput("leftServe", 316, 237, 0, 1, 0, 3, 9, 1);
      applyStimulus(2, 1);
      checkOutput("leftMove", 312, 235, 0, 1, 0, 3, 9, 1);

      @(negedge pixel_clk);
      reset_n = 1'b0;
      #1;
      checkOutput("asyncReset", 318, 238, 0, 0, 0, 3, 9, 1);
      @(negedge pixel_clk);
      @(negedge pixel_clk);
      reset_n = 1'b1;
      applyStimulus(3, 1);
      checkOutput("postReset", 318, 238, 0, 0, 0, 3, 9, 1);

      repeat (5) @(negedge pixel_clk);
      checkCount++;
      if (sbQueue.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL scoreboardDrain: actual %0d pending required 0", sbQueue.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
